// File: rtl/b2_counter_pkg.sv
// Shared constants for the base-2 counter family.
// Holds the default and maximum counter widths used by b2_up_counter.
package b2_counter_pkg;

    localparam int unsigned B2_DEFAULT_WIDTH = 32'd1;
    localparam int unsigned B2_MAX_WIDTH     = 32'd32;

    // True when a requested counter width lies inside the supported range.
    function automatic logic b2_width_ok(input int unsigned width);
        b2_width_ok = (width >= 32'd1) && (width <= B2_MAX_WIDTH);
    endfunction

endpackage : b2_counter_pkg

// File: rtl/b2_counter_cell.sv
// One bit of a base-2 up counter: toggles when its carry-in is high and
// passes the carry on once this bit is already at 1.
module b2_counter_cell (
    input  logic clock,
    input  logic reset_,
    input  logic ci,
    output logic q_bit,
    output logic co
);

    logic bit_q;
    logic bit_d;

    // Next-state: toggle on carry-in, otherwise hold.
    always_comb begin
        if (ci) begin
            bit_d = ~bit_q;
        end else begin
            bit_d = bit_q;
        end
    end

    // Count bit with asynchronous active-high clear.
    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign q_bit = bit_q;
    assign co    = ci & bit_q;

endmodule : b2_counter_cell

// File: rtl/b2_up_counter.sv
// Cascadable WIDTH-bit binary up counter built from a ripple-enable chain of
// single-bit cells; every bit shares the same clock edge.
module b2_up_counter
    import b2_counter_pkg::*;
#(
    parameter int unsigned WIDTH = B2_DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             ei,
    output logic             eu,
    output logic [WIDTH-1:0] q
);

    localparam logic WIDTH_LEGAL = b2_width_ok(WIDTH);

    // Carry chain: element k feeds cell k, element WIDTH leaves as eu.
    logic [WIDTH:0] carry_s;

    assign carry_s[0] = ei;

    for (genvar k = 0; k < WIDTH; k++) begin : g_cell
        b2_counter_cell u_cell (
            .clock  (clock),
            .reset_ (reset_),
            .ci     (carry_s[k]),
            .q_bit  (q[k]),
            .co     (carry_s[k+1])
        );
    end

    // An out-of-range WIDTH still elaborates, but never reports a carry-out.
    assign eu = carry_s[WIDTH] & WIDTH_LEGAL;

endmodule : b2_up_counter

// File: tb/tb_b2_up_counter.sv
// Self-checking bench for b2_up_counter: directed scenarios plus randomized
// enables compared against a plain-arithmetic model of the count.
module tb_b2_up_counter;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic       ei1   = 1'b0;
    logic       ei4   = 1'b0;
    logic       eic   = 1'b0;
    logic       ei5   = 1'b0;
    logic       eu1, eu4, euc0, euc1, eu5;
    logic [0:0] q1, qc0, qc1;
    logic [3:0] q4;
    logic [4:0] q5;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    b2_up_counter #(.WIDTH(1)) u_w1 (.clock(clock), .reset_(rst), .ei(ei1), .eu(eu1), .q(q1));
    b2_up_counter #(.WIDTH(4)) u_w4 (.clock(clock), .reset_(rst), .ei(ei4), .eu(eu4), .q(q4));
    b2_up_counter #(.WIDTH(1)) u_c0 (.clock(clock), .reset_(rst), .ei(eic), .eu(euc0), .q(qc0));
    b2_up_counter #(.WIDTH(1)) u_c1 (.clock(clock), .reset_(rst), .ei(euc0), .eu(euc1), .q(qc1));
    b2_up_counter #(.WIDTH(5)) u_w5 (.clock(clock), .reset_(rst), .ei(ei5), .eu(eu5), .q(q5));

    // Assert reset between edges and confirm everything clears without a clock edge.
    task automatic test_reset();
        @(negedge clock);
        ei1 = 1'b0; ei4 = 1'b0; eic = 1'b0; ei5 = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({q1, q4, qc0, qc1, q5} !== 12'd0) begin
            errors++;
            $display("FAIL reset_q: got %b required 0", {q1, q4, qc0, qc1, q5});
        end
        checks++;
        if ({eu1, eu4, euc0, euc1, eu5} !== 5'd0) begin
            errors++;
            $display("FAIL reset_eu: got %b required 0", {eu1, eu4, euc0, euc1, eu5});
        end
        @(negedge clock);
        rst = 1'b0;
    endtask

    // WIDTH=1 toggling: q follows 1,0,1,0 and eu mirrors q while enabled.
    task automatic test_toggle();
        int m = 0;
        test_reset();
        ei1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            m = (m + 1) % 2;
            @(negedge clock);
            checks++;
            if (q1 !== 1'(m)) begin
                errors++;
                $display("FAIL toggle_q[%0d]: got %b required %0d", i, q1, m);
            end
            checks++;
            if (eu1 !== (m == 1)) begin
                errors++;
                $display("FAIL toggle_eu[%0d]: got %b required %0d", i, eu1, m == 1);
            end
        end
    endtask

    // WIDTH=1 hold at q=1 with the enable low.
    task automatic test_hold();
        test_reset();
        ei1 = 1'b1;
        @(negedge clock);
        ei1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (q1 !== 1'b1 || eu1 !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got q=%b eu=%b required q=1 eu=0", i, q1, eu1);
            end
        end
    endtask

    // WIDTH=4 full wrap: 0..15 then 0, eu only while q=15.
    task automatic test_wrap();
        int m = 0;
        test_reset();
        ei4 = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            #1;
            checks++;
            if (q4 !== 4'(m) || eu4 !== (m == 15)) begin
                errors++;
                $display("FAIL wrap[%0d]: got q=%0d eu=%b required q=%0d eu=%0d", i, q4, eu4, m, m == 15);
            end
            @(posedge clock);
            m = (m + 1) % 16;
            @(negedge clock);
        end
    endtask

    // Reset pulse between edges at q=9, then counting restarts from 1.
    task automatic test_mid_reset();
        test_reset();
        ei4 = 1'b1;
        repeat (9) @(negedge clock);
        checks++;
        if (q4 !== 4'd9) begin
            errors++;
            $display("FAIL mid_pre: got %0d required 9", q4);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (q4 !== 4'd0 || eu4 !== 1'b0) begin
            errors++;
            $display("FAIL mid_clear: got q=%0d eu=%b required q=0 eu=0", q4, eu4);
        end
        #1 rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            checks++;
            if (q4 !== 4'(i)) begin
                errors++;
                $display("FAIL mid_resume[%0d]: got %0d required %0d", i, q4, i);
            end
        end
    endtask

    // Two WIDTH=1 stages chained through eu form a 2-bit counter.
    task automatic test_cascade();
        int m = 0;
        test_reset();
        eic = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            m = (m + 1) % 4;
            @(negedge clock);
            checks++;
            if ({qc1, qc0} !== 2'(m) || euc1 !== (m == 3)) begin
                errors++;
                $display("FAIL cascade[%0d]: got q=%0d eu=%b required q=%0d eu=%0d", i, {qc1, qc0}, euc1, m, m == 3);
            end
        end
    endtask

    // 20 enabled edges give exactly 10 rising transitions, never any X.
    task automatic test_long_run();
        int   rises = 0;
        int   xs    = 0;
        logic prev;
        test_reset();
        ei1  = 1'b1;
        prev = q1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if ($isunknown({q1, eu1})) xs++;
            if (prev === 1'b0 && q1 === 1'b1) rises++;
            prev = q1;
        end
        checks++;
        if (rises !== 10) begin
            errors++;
            $display("FAIL long_rises: got %0d required 10", rises);
        end
        checks++;
        if (xs !== 0) begin
            errors++;
            $display("FAIL long_x: got %0d unknown samples required 0", xs);
        end
    endtask

    // Random enables on WIDTH=5, with occasional asynchronous reset pulses.
    task automatic test_random();
        int m = 0;
        int bad = 0;
        test_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
                m = 0;
            end
            ei5 = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (q5 !== 5'(m) || eu5 !== (ei5 && m == 31)) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random[%0d]: got q=%0d eu=%b required q=%0d eu=%0d", i, q5, eu5, m, ei5 && m == 31);
            end
            @(posedge clock);
            if (ei5) m = (m + 1) % 32;
            @(negedge clock);
        end
        ei5 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_hold();
        test_wrap();
        test_mid_reset();
        test_cascade();
        test_long_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_b2_up_counter
